// File: rtl/ddr3_req_sched.sv
// ddr3_req_sched: arbitrates client read/write requests and periodic refreshes
// onto a single-command DDR3 controller. At most one command is outstanding.
//
// Ports:
//   clk, sys_resetn           single clock; asynchronous active-low reset
//   req_valid/we/addr/wdata   client request; accepted when req_valid && req_ready
//   req_ready                 scheduler can accept a request this cycle
//   rsp_valid/rsp_data        one-cycle read response
//   ctl_rd/wr/refresh         one-cycle command pulses to the controller
//   ctl_addr/ctl_din          command operands, held until the next command
//   ctl_busy/data_ready/dout  controller status and read data
//   refresh_count             refreshes issued (wraps)
//   refresh_overrun           sticky: refresh debt overflowed
module ddr3_req_sched #(
  parameter int unsigned REFRESH_CYCLES = 615,
  parameter int unsigned MAX_DEBT       = 8,
  parameter int unsigned URGENT_DEBT    = 4
) (
  input  logic        clk,
  input  logic        sys_resetn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [25:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        ctl_rd,
  output logic        ctl_wr,
  output logic        ctl_refresh,
  output logic [25:0] ctl_addr,
  output logic [15:0] ctl_din,
  input  logic        ctl_busy,
  input  logic        ctl_data_ready,
  input  logic [15:0] ctl_dout,
  output logic [23:0] refresh_count,
  output logic        refresh_overrun
);

  localparam int unsigned TimerW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned DebtW  = (MAX_DEBT > 0) ? $clog2(MAX_DEBT + 1) : 1;

  localparam logic [TimerW-1:0] TimerLast  = TimerW'(REFRESH_CYCLES - 1);
  localparam logic [DebtW-1:0]  DebtMax    = DebtW'(MAX_DEBT);
  localparam logic [DebtW-1:0]  DebtUrgent = DebtW'(URGENT_DEBT);

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StWaitRd,
    StWaitBusy
  } state_e;

  typedef enum logic [1:0] {
    OpRead,
    OpWrite,
    OpRefresh
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [DebtW-1:0]  debt_q, debt_d;
  logic [23:0]       refresh_count_q, refresh_count_d;
  logic              overrun_q, overrun_d;
  logic              ctl_rd_q, ctl_rd_d;
  logic              ctl_wr_q, ctl_wr_d;
  logic              ctl_refresh_q, ctl_refresh_d;
  logic [25:0]       ctl_addr_q, ctl_addr_d;
  logic [15:0]       ctl_din_q, ctl_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_data_q, rsp_data_d;

  logic timer_wrap;
  logic idle_free;
  logic refresh_issue;
  logic accept;
  logic capture_rd;

  assign timer_wrap = (timer_q == TimerLast);
  assign idle_free  = (state_q == StIdle) && !ctl_busy;

  // Urgent debt pre-empts clients; otherwise refresh only into an idle bus.
  assign refresh_issue = idle_free &&
                         ((debt_q >= DebtUrgent) || ((debt_q != '0) && !req_valid));

  // Gated by reset so a held-low reset never advertises readiness.
  assign req_ready = sys_resetn && idle_free && !refresh_issue;
  assign accept    = req_valid && req_ready;

  // Read data may arrive already in the guard cycle; both windows capture it.
  assign capture_rd = (op_q == OpRead) && ctl_data_ready &&
                      ((state_q == StGuard) || (state_q == StWaitRd));

  // Command FSM and output registers.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ctl_rd_d      = 1'b0;
    ctl_wr_d      = 1'b0;
    ctl_refresh_d = 1'b0;
    ctl_addr_d    = ctl_addr_q;
    ctl_din_d     = ctl_din_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;

    if (capture_rd) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = ctl_dout;
    end

    unique case (state_q)
      StIdle: begin
        if (refresh_issue) begin
          ctl_refresh_d = 1'b1;
          op_d          = OpRefresh;
          state_d       = StGuard;
        end else if (accept) begin
          ctl_addr_d = req_addr;
          ctl_din_d  = req_wdata;
          ctl_wr_d   = req_we;
          ctl_rd_d   = !req_we;
          op_d       = req_we ? OpWrite : OpRead;
          state_d    = StGuard;
        end
      end
      // Single cycle that ignores ctl_busy: the controller raises busy a cycle late.
      StGuard: begin
        if ((op_q == OpRead) && !ctl_data_ready) begin
          state_d = StWaitRd;
        end else begin
          state_d = StWaitBusy;
        end
      end
      StWaitRd: begin
        if (ctl_data_ready) begin
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!ctl_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh timer and debt run independently of the command FSM.
  always_comb begin
    timer_d         = timer_wrap ? '0 : timer_q + TimerW'(1);
    debt_d          = debt_q;
    overrun_d       = overrun_q;
    refresh_count_d = refresh_count_q;

    if (refresh_issue) begin
      refresh_count_d = refresh_count_q + 24'd1;
    end

    // A wrap coinciding with an issue cancels out.
    if (timer_wrap && !refresh_issue) begin
      if (debt_q == DebtMax) begin
        overrun_d = 1'b1;
      end else begin
        debt_d = debt_q + DebtW'(1);
      end
    end else if (!timer_wrap && refresh_issue) begin
      debt_d = debt_q - DebtW'(1);
    end
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q         <= StIdle;
      op_q            <= OpRead;
      timer_q         <= '0;
      debt_q          <= '0;
      refresh_count_q <= '0;
      overrun_q       <= 1'b0;
      ctl_rd_q        <= 1'b0;
      ctl_wr_q        <= 1'b0;
      ctl_refresh_q   <= 1'b0;
      ctl_addr_q      <= '0;
      ctl_din_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      timer_q         <= timer_d;
      debt_q          <= debt_d;
      refresh_count_q <= refresh_count_d;
      overrun_q       <= overrun_d;
      ctl_rd_q        <= ctl_rd_d;
      ctl_wr_q        <= ctl_wr_d;
      ctl_refresh_q   <= ctl_refresh_d;
      ctl_addr_q      <= ctl_addr_d;
      ctl_din_q       <= ctl_din_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign ctl_rd          = ctl_rd_q;
  assign ctl_wr          = ctl_wr_q;
  assign ctl_refresh     = ctl_refresh_q;
  assign ctl_addr        = ctl_addr_q;
  assign ctl_din         = ctl_din_q;
  assign refresh_count   = refresh_count_q;
  assign refresh_overrun = overrun_q;

endmodule
